vec_result_collector: RTL and testbench



---
 rtl/fhe_alu_pkg.sv | 14 +
 rtl/vec_result_collector_fifo.sv | 57 +++++
 rtl/vec_result_collector.sv | 144 ++++++++++++++
 tb/tb_vec_result_collector.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_alu_pkg.sv
// FHE ALU shared package: operand width plus result collector types.
// FSIZE is the element width used across the modular multiplier datapath.
package FHE_ALU_PKG;

   localparam int FSIZE           = 64;
   localparam int COLLECTOR_DEPTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      FLUSH
   } collector_state_t;

endpackage

// File: rtl/vec_result_collector_fifo.sv
// collector_fifo: synchronous show-ahead FIFO; dout is the head entry.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module collector_fifo #(
   parameter int DATA_SIZE = 65,
   parameter int DEPTH     = 64
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_SIZE-1:0]     din,
   output logic [DATA_SIZE-1:0]     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          occ_q, occ_d;
   logic                 do_push, do_pop;

   assign full      = (occ_q == (AW+1)'(DEPTH));
   assign empty     = (occ_q == '0);
   assign occupancy = occ_q;
   assign dout      = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
      occ_d    = occ_q + {{AW{1'b0}}, do_push}
                       - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/vec_result_collector.sv
// Result collector: buffers multiplier output, issues credits, tracks vectors.
// Define COLLECTOR_STATS_EN to build the stall_cycles counter.
module vec_result_collector
   import FHE_ALU_PKG::*;
#(
   parameter int DEPTH = COLLECTOR_DEPTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             issue_req,
   output logic             issue_ok,
   input  logic [FSIZE-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic [FSIZE-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic [CNT_W-1:0] vec_count,
   output logic             vec_done,
   output logic             busy,
   output logic             overflow,
   output logic [31:0]      stall_cycles
);

   localparam int AW = $clog2(DEPTH);

   logic [FSIZE:0]   head;
   logic             full, empty;
   logic [AW:0]      occ;
   logic [AW+1:0]    credit_sum;

   collector_state_t state_q, state_d;
   logic [AW:0]      inflight_q, inflight_d;
   logic [AW:0]      pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;

   logic issue_fire, pop, push_ok, push_last, pop_last, drained;

   collector_fifo #(
      .DATA_SIZE (FSIZE + 1),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (in_valid),
      .pop       (pop),
      .din       ({in_last, in_data}),
      .dout      (head),
      .full      (full),
      .empty     (empty),
      .occupancy (occ)
   );

   // Credit uses registered state only; same-cycle pops are not credited.
   assign credit_sum = {1'b0, occ} + {1'b0, inflight_q};
   assign issue_ok   = (credit_sum < (AW+2)'(DEPTH));
   assign issue_fire = issue_req & issue_ok;

   assign m_valid   = ~empty;
   assign m_data    = empty ? '0 : head[FSIZE-1:0];
   assign m_last    = ~empty & head[FSIZE];
   assign vec_count = cnt_q;
   assign vec_done  = done_q;
   assign busy      = (state_q != IDLE);
   assign overflow  = ovf_q;

   always_comb begin
      pop        = m_valid & m_ready;
      push_ok    = in_valid & (~full | pop);
      push_last  = push_ok & in_last;
      pop_last   = pop & head[FSIZE];
      inflight_d = inflight_q;
      ovf_d      = ovf_q | (in_valid & full & ~pop);
      if (issue_fire & ~in_valid) begin
         inflight_d = inflight_q + 1'b1;
      end else if (~issue_fire & in_valid) begin
         if (inflight_q == '0) ovf_d = 1'b1;
         else                  inflight_d = inflight_q - 1'b1;
      end
      cnt_d = cnt_q;
      if (pop) cnt_d = pop_last ? '0 : cnt_q + 1'b1;
      done_d  = pop_last;
      pend_d  = pend_q + {{AW{1'b0}}, push_last}
                       - {{AW{1'b0}}, pop_last};
      drained = (occ == (AW+1)'(1)) & ~push_ok
              & (inflight_d == '0);
      state_d = state_q;
      // A pending last entry re-enters FLUSH for back-to-back vectors.
      unique case (state_q)
         IDLE: begin
            if (push_last)                  state_d = FLUSH;
            else if (issue_fire | in_valid) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (push_last | (pend_q != '0)) state_d = FLUSH;
         end
         FLUSH: begin
            if (pop_last) state_d = drained ? IDLE : ACTIVE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         inflight_q <= '0;
         pend_q     <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef COLLECTOR_STATS_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (m_valid & ~m_ready & (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_vec_result_collector.sv
// Scoreboard bench for vec_result_collector with a fixed-latency upstream model.
// Expected entries are queued at issue time and checked by a separate monitor.
module tb_vec_result_collector;
   import FHE_ALU_PKG::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam int LAT   = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             issue_req = 1'b0;
   logic             issue_ok;
   logic [FSIZE-1:0] in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic [FSIZE-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             m_ready = 1'b0;
   logic [CNT_W-1:0] vec_count;
   logic             vec_done;
   logic             busy;
   logic             overflow;
   logic [31:0]      stall_cycles;

   vec_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .issue_req    (issue_req),
      .issue_ok     (issue_ok),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_last       (m_last),
      .m_ready      (m_ready),
      .vec_count    (vec_count),
      .vec_done     (vec_done),
      .busy         (busy),
      .overflow     (overflow),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   int               n_vec = 0;
   int               n_err = 0;
   logic [FSIZE:0]   sb_q[$];
   int               vec_lens[$];
   int               elem_idx = 0;
   int               fires = 0;
   int               done_seen = 0;
   bit               issue_en = 0;
   bit               manual = 0;
   bit               mon_en = 0;
   logic             man_valid = 1'b0;
   logic             man_last = 1'b0;
   logic [FSIZE-1:0] man_data = '0;
   logic [FSIZE-1:0] next_data = 64'h1000;
   int               exp_cnt = 0;
   bit               exp_done = 0;
   logic [FSIZE:0]   pipe [LAT];
   bit               pipe_v [LAT];
   logic [31:0]      exp_stall;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((sb_q.size() != 0 || vec_lens.size() != 0) && k < 300) begin
         step();
         k++;
      end
      if (k >= 300) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: timeout with %0d entries outstanding",
                  name, sb_q.size());
      end
      step();
      step();
   endtask

   // Upstream issuer + fixed-latency multiplier, driven on the falling edge.
   initial begin : upstream
      logic fire, last;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            for (int i = 0; i < LAT; i++) pipe_v[i] = 0;
            issue_req = 1'b0;
            in_valid  = 1'b0;
            in_last   = 1'b0;
         end else begin
            for (int i = LAT - 1; i > 0; i--) begin
               pipe_v[i] = pipe_v[i-1];
               pipe[i]   = pipe[i-1];
            end
            issue_req = issue_en && (vec_lens.size() > 0);
            fire      = issue_req && issue_ok;
            pipe_v[0] = fire;
            if (fire) begin
               last    = (elem_idx == vec_lens[0] - 1);
               pipe[0] = {last, next_data};
               sb_q.push_back({last, next_data});
               next_data = next_data + 1;
               fires++;
               if (last) begin
                  void'(vec_lens.pop_front());
                  elem_idx = 0;
               end else begin
                  elem_idx++;
               end
            end
            if (manual) begin
               in_valid = man_valid;
               in_last  = man_last;
               in_data  = man_data;
            end else begin
               in_valid = pipe_v[LAT-1];
               {in_last, in_data} = pipe[LAT-1];
            end
         end
      end
   end

   // Monitor: samples just before each rising edge.
   initial begin : monitor
      logic [FSIZE:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (mon_en && rstn) begin
            chk("vec_count", 64'(vec_count), 64'(exp_cnt));
            chk("vec_done", 64'(vec_done), 64'(exp_done));
            if (vec_done) done_seen++;
            exp_done = 0;
            if (m_valid && m_ready) begin
               if (sb_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_pop: got %0h expected none",
                           m_data);
               end else begin
                  e = sb_q.pop_front();
                  chk("m_data", m_data, e[FSIZE-1:0]);
                  chk("m_last", 64'(m_last), 64'(e[FSIZE]));
                  exp_done = e[FSIZE];
                  exp_cnt  = e[FSIZE] ? 0 : exp_cnt + 1;
               end
            end
         end
      end
   end

   initial begin
      repeat (3) step();
      chk("rst_issue_ok", 64'(issue_ok), 64'd1);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_stall", 64'(stall_cycles), 64'd0);
      rstn   = 1'b1;
      mon_en = 1;
      step();

      // Single vector of 8, writeback always ready.
      m_ready  = 1'b1;
      issue_en = 1;
      vec_lens.push_back(8);
      step();
      step();
      chk("busy_active", 64'(busy), 64'd1);
      wait_drain("single_vec");
      chk("single_fires", 64'(fires), 64'd8);
      chk("single_done", 64'(done_seen), 64'd1);
      chk("single_idle", 64'(busy), 64'd0);
      chk("single_ovf", 64'(overflow), 64'd0);

      // Credit throttle with writeback stalled.
      m_ready = 1'b0;
      vec_lens.push_back(6);
      repeat (12) step();
      chk("throttle_fires", 64'(fires), 64'd12);
      chk("throttle_ok_low", 64'(issue_ok), 64'd0);
      chk("throttle_valid", 64'(m_valid), 64'd1);
      m_ready = 1'b1;
      chk("throttle_pre_pop", 64'(issue_ok), 64'd0);
      step();
      chk("throttle_ok_back", 64'(issue_ok), 64'd1);
      wait_drain("throttle");
      chk("throttle_total", 64'(fires), 64'd14);
      chk("throttle_done", 64'(done_seen), 64'd2);

      // Back-to-back vectors of 3 and 5.
      vec_lens.push_back(3);
      vec_lens.push_back(5);
      wait_drain("b2b");
      chk("b2b_fires", 64'(fires), 64'd22);
      chk("b2b_done", 64'(done_seen), 64'd4);
      chk("b2b_idle", 64'(busy), 64'd0);
      chk("b2b_ovf", 64'(overflow), 64'd0);

      // Fill the FIFO, then force a push with no pop.
      m_ready = 1'b0;
      vec_lens.push_back(4);
      repeat (8) step();
      chk("full_ok_low", 64'(issue_ok), 64'd0);
      manual    = 1;
      man_valid = 1'b1;
      man_last  = 1'b0;
      man_data  = 64'hDEAD;
      step();
      man_valid = 1'b0;
      step();
      chk("ovf_set", 64'(overflow), 64'd1);
      repeat (3) step();
      chk("ovf_sticky", 64'(overflow), 64'd1);
      chk("ovf_head", m_data, 64'h1016);

      // Push and pop together on a full FIFO.
      m_ready   = 1'b1;
      man_valid = 1'b1;
      man_data  = 64'hBEEF;
      sb_q.push_back({1'b0, 64'hBEEF});
      step();
      man_valid = 1'b0;
      m_ready   = 1'b0;
      step();
      chk("fullpp_valid", 64'(m_valid), 64'd1);
      chk("fullpp_occ4", 64'(issue_ok), 64'd0);
      chk("fullpp_head", m_data, 64'h1017);
      m_ready = 1'b1;
      manual  = 0;
      wait_drain("fullpp");
      chk("fullpp_done", 64'(done_seen), 64'd5);

      // Reset with three entries buffered.
      m_ready = 1'b0;
      vec_lens.push_back(3);
      repeat (6) step();
      chk("mid_valid", 64'(m_valid), 64'd1);
      mon_en = 0;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_issue_ok", 64'(issue_ok), 64'd1);
      chk("arst_m_valid", 64'(m_valid), 64'd0);
      chk("arst_m_last", 64'(m_last), 64'd0);
      chk("arst_m_data", m_data, 64'd0);
      chk("arst_vec_count", 64'(vec_count), 64'd0);
      chk("arst_vec_done", 64'(vec_done), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_overflow", 64'(overflow), 64'd0);
      chk("arst_stall", 64'(stall_cycles), 64'd0);
      sb_q.delete();
      vec_lens.delete();
      elem_idx = 0;
      exp_cnt  = 0;
      exp_done = 0;
      step();
      step();
      rstn   = 1'b1;
      mon_en = 1;
      step();

      // Stall counter over ten blocked cycles.
      vec_lens.push_back(1);
      for (int i = 0; i < 20 && !m_valid; i++) step();
      chk("stats_valid", 64'(m_valid), 64'd1);
      repeat (10) step();
`ifdef COLLECTOR_STATS_EN
      exp_stall = 32'd10;
`else
      exp_stall = 32'd0;
`endif
      chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
      m_ready = 1'b1;
      wait_drain("stats");
      chk("final_idle", 64'(busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
